// File: rtl/keypad_scan_ctrl_if.sv
// Key FIFO read port: head code plus valid/ready handshake toward the entry logic.
interface keypad_scan_ctrl_if;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_ready;

   modport master (output key_code, output key_valid, input key_ready);
   modport slave  (input key_code, input key_valid, output key_ready);
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: sequenced column strobes, debounced press/release, key FIFO.
// Auto-repeat while a key is held is built only when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_scan_ctrl #(
   parameter int DIV    = 50000,
   parameter int DEB    = 4,
   parameter int DEPTH  = 4,
   parameter int REPEAT = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0]         row,
   output logic [3:0]         col,
   output logic               overflow,
   keypad_scan_ctrl_if.master key_if
);
   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int DW = $clog2(DEB + 1);
   localparam int AW = $clog2(DEPTH);
   localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);
   localparam logic [DW-1:0] DEB_W    = DW'(DEB);
   localparam bit PARAMS_OK = (DIV >= 2) && (DEB >= 1) && (DEPTH >= 2) &&
                              ((DEPTH & (DEPTH - 1)) == 0) && (REPEAT >= 1);

   if (!PARAMS_OK) begin : g_bad_params
      $error("keypad_scan_ctrl: illegal parameter set");
   end

   typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

   state_t        state_reg, state_next;
   logic [3:0]    row_meta_reg, row_sync_reg;
   logic [PW-1:0] presc_reg;
   logic          tick;
   logic [3:0]    col_reg, col_next, col_rot;
   logic [3:0]    pat_reg, pat_next;
   logic [DW-1:0] deb_reg, deb_next, deb_inc;
   logic          rows_idle;
   logic [1:0]    row_idx, col_idx;
   logic          push_req;
   logic [3:0]    push_code;

   logic [3:0]    mem_reg [DEPTH];
   logic [AW:0]   wr_ptr_reg, rd_ptr_reg;
   logic          ovf_reg;
   logic          fifo_empty, fifo_full, pop, push_ok;

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int RW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT - 1);
   logic [RW-1:0] rep_reg, rep_next;
   logic [3:0]    code_reg, code_next;
`endif

   // Two-flop synchroniser; idles high so a reset never looks like a press.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row_meta_reg <= 4'hF;
         row_sync_reg <= 4'hF;
      end else begin
         row_meta_reg <= row;
         row_sync_reg <= row_meta_reg;
      end
   end

   assign tick = (presc_reg == DIV_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) presc_reg <= '0;
      else      presc_reg <= tick ? '0 : presc_reg + PW'(1);
   end

   assign rows_idle = &row_sync_reg;
   assign col_rot   = {col_reg[2:0], col_reg[3]};
   assign deb_inc   = deb_reg + DW'(1);

   // Lowest sensed row wins; the column strobe is one-hot-low.
   always_comb begin
      row_idx = 2'd0;
      col_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!row_sync_reg[i]) row_idx = 2'(i);
         if (!col_reg[i])      col_idx = 2'(i);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_reg <= SCAN;
      else      state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      col_next   = col_reg;
      pat_next   = pat_reg;
      deb_next   = deb_reg;
      push_req   = 1'b0;
      push_code  = {row_idx, col_idx};
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_next   = rep_reg;
      code_next  = code_reg;
`endif
      if (tick) begin
         case (state_reg)
            SCAN: begin
               if (rows_idle) begin
                  col_next = col_rot;
               end else begin
                  pat_next = row_sync_reg;
                  deb_next = DW'(1);
                  if (DEB == 1) begin
                     push_req   = 1'b1;
                     state_next = PRESSED;
                  end else begin
                     state_next = DEBOUNCE;
                  end
               end
            end
            DEBOUNCE: begin
               if (rows_idle) begin
                  state_next = SCAN;
                  col_next   = col_rot;
               end else if (row_sync_reg != pat_reg) begin
                  pat_next = row_sync_reg;
                  deb_next = DW'(1);
               end else begin
                  deb_next = deb_inc;
                  if (deb_inc == DEB_W) begin
                     push_req   = 1'b1;
                     state_next = PRESSED;
                  end
               end
            end
            PRESSED: begin
               if (rows_idle) begin
                  deb_next = DW'(1);
                  if (DEB == 1) begin
                     state_next = SCAN;
                     col_next   = col_rot;
                  end else begin
                     state_next = RELEASE;
                  end
               end
`ifdef KEYPAD_AUTOREPEAT_EN
               else if (rep_reg == REP_LAST) begin
                  push_req  = 1'b1;
                  push_code = code_reg;
                  rep_next  = '0;
               end else begin
                  rep_next = rep_reg + RW'(1);
               end
`endif
            end
            RELEASE: begin
               // A bounce back to low returns to PRESSED without a second push.
               if (!rows_idle) begin
                  state_next = PRESSED;
               end else begin
                  deb_next = deb_inc;
                  if (deb_inc == DEB_W) begin
                     state_next = SCAN;
                     col_next   = col_rot;
                  end
               end
            end
            default: state_next = SCAN;
         endcase
`ifdef KEYPAD_AUTOREPEAT_EN
         if (push_req && state_reg != PRESSED) begin
            rep_next  = '0;
            code_next = push_code;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_reg <= 4'b1110;
         pat_reg <= 4'hF;
         deb_reg <= '0;
      end else begin
         col_reg <= col_next;
         pat_reg <= pat_next;
         deb_reg <= deb_next;
      end
   end

`ifdef KEYPAD_AUTOREPEAT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rep_reg  <= '0;
         code_reg <= 4'h0;
      end else begin
         rep_reg  <= rep_next;
         code_reg <= code_next;
      end
   end
`endif

   // Extra pointer bit separates full from empty; a pop frees room for a same-cycle push.
   assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
   assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign pop        = !fifo_empty && key_if.key_ready;
   assign push_ok    = push_req && (!fifo_full || pop);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         ovf_reg    <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_reg[i] <= 4'h0;
      end else begin
         if (push_ok) begin
            mem_reg[wr_ptr_reg[AW-1:0]] <= push_code;
            wr_ptr_reg                  <= wr_ptr_reg + (AW+1)'(1);
         end
         if (pop) rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
         if (push_req && !push_ok) ovf_reg <= 1'b1;
      end
   end

   always_comb begin
      col              = col_reg;
      overflow         = ovf_reg;
      key_if.key_valid = !fifo_empty;
      key_if.key_code  = mem_reg[rd_ptr_reg[AW-1:0]];
   end
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Randomised keypad bench: a key-matrix model drives row from col, a scoreboard checks the key FIFO.
module tb_keypad_scan_ctrl;
   localparam int DIV   = 8;
   localparam int DEB   = 2;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  row;
   logic [3:0]  col;
   logic        overflow;
   logic [15:0] held = '0;
   logic        ready_fix = 1'b1;
   bit          rand_ready = 1'b0;

   int          n_vec = 0;
   int          n_err = 0;
   logic [3:0]  exp_q[$];
   logic        ovf_model = 1'b0;

   keypad_scan_ctrl_if kif ();

   keypad_scan_ctrl #(.DIV(DIV), .DEB(DEB), .DEPTH(DEPTH), .REPEAT(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .row      (row),
      .col      (col),
      .overflow (overflow),
      .key_if   (kif)
   );

   always #5 clk = ~clk;

   // Physical matrix: a held key at (r,c) pulls row r low while column c is strobed.
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (held[r*4+c] && !col[c]) row[r] = 1'b0;
   end

   initial begin
      kif.key_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         kif.key_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fix;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every accepted head is compared with the oldest expected code.
   initial begin
      forever begin
         @(negedge clk);
         if (rst && kif.key_valid && kif.key_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_key: got %h, expected no key", kif.key_code);
            end else begin
               check("key_code", kif.key_code, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [3:0] col_of(input int c);
      logic [3:0] v;
      v = 4'hF;
      v[c] = 1'b0;
      return v;
   endfunction

   function automatic void model_press(input logic [3:0] code);
      if (exp_q.size() < DEPTH) exp_q.push_back(code);
      else                      ovf_model = 1'b1;
   endfunction

   task automatic wait_col_enter(input logic [3:0] target);
      int n = 0;
      while (col == target && n < 8*DIV) begin @(negedge clk); n++; end
      while (col != target && n < 8*DIV) begin @(negedge clk); n++; end
      check("col_reach", {col, 1'b0 + (n < 8*DIV)}, {target, 1'b1});
   endtask

   task automatic wait_col_leave(input logic [3:0] target, input int c);
      int n = 0;
      while (col == target && n < 4*DIV) begin @(negedge clk); n++; end
      check("col_advance", col, col_of((c + 1) % 4));
   endtask

   task automatic press(input int c, input logic [3:0] rows_mask, input int extra);
      int r = 0;
      logic [15:0] m = '0;
      for (int i = 3; i >= 0; i--) if (rows_mask[i]) r = i;
      for (int i = 0; i < 4; i++) if (rows_mask[i]) m[i*4+c] = 1'b1;
      model_press(4'(r*4 + c));
      wait_col_enter(col_of(c));
      held = m;
      repeat (3*DIV + extra) @(negedge clk);
      check("col_parked", col, col_of(c));
      held = '0;
      wait_col_leave(col_of(c), c);
      repeat (DIV) @(negedge clk);
   endtask

   task automatic bounce(input int c, input int r);
      logic [15:0] m = '0;
      m[r*4+c] = 1'b1;
      wait_col_enter(col_of(c));
      held = m;
      repeat (DIV + 2) @(negedge clk);
      held = '0;
      wait_col_leave(col_of(c), c);
   endtask

   initial begin
      int n;
      int c;
      logic [3:0] prev;

      repeat (5) @(negedge clk);
      check("rst_col", col, 4'b1110);
      check("rst_valid", kif.key_valid, 1'b0);
      check("rst_code", kif.key_code, 4'h0);
      check("rst_ovf", overflow, 1'b0);
      rst = 1'b1;

      // Idle scan: column rotates every DIV clocks.
      for (int k = 0; k < 8; k++) begin
         prev = col;
         n = 0;
         while (col == prev && n < 3*DIV) begin @(negedge clk); n++; end
         check("scan_col", col, col_of((k + 1) % 4));
         if (k > 0) check("scan_period", n, DIV);
      end
      check("scan_valid", kif.key_valid, 1'b0);
      check("scan_ovf", overflow, 1'b0);

      press(2, 4'b0010, 0);
      bounce(1, 1);
      press(0, 4'b0110, 0);

      rand_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         c = $urandom_range(0, 3);
         if ($urandom_range(0, 3) == 0) bounce(c, $urandom_range(0, 3));
         else if ($urandom_range(0, 3) == 0) press(c, 4'($urandom_range(1, 15)), $urandom_range(0, 20));
         else press(c, 4'b0001 << $urandom_range(0, 3), $urandom_range(0, 20));
      end
      rand_ready = 1'b0;
      ready_fix  = 1'b1;
      repeat (4) @(negedge clk);
      check("drained", kif.key_valid, 1'b0);

      // Consumer stalled: the fifth confirmed key must be dropped.
      ready_fix = 1'b0;
      repeat (2) @(negedge clk);
      press(0, 4'b0100, 0);
      press(1, 4'b0001, 3);
      press(2, 4'b1000, 5);
      press(3, 4'b0010, 1);
      check("full_ovf", overflow, ovf_model);
      press(1, 4'b1000, 0);
      check("drop_ovf", overflow, ovf_model);
      check("full_valid", kif.key_valid, 1'b1);
      ready_fix = 1'b1;
      repeat (10) @(negedge clk);
      check("empty_valid", kif.key_valid, 1'b0);

      // Asynchronous reset mid-debounce: pending key is lost, flags clear at once.
      wait_col_enter(col_of(2));
      held = 16'h0001 << (1*4 + 2);
      repeat (DIV + 2) @(negedge clk);
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check("arst_col", col, 4'b1110);
      check("arst_ovf", overflow, 1'b0);
      check("arst_valid", kif.key_valid, 1'b0);
      held = '0;
      @(negedge clk);
      rst = 1'b1;
      repeat (6*DIV) @(negedge clk);

      check("pending", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
